// File: rtl/branch_predictor_if.sv
// Branch predictor bundle between the fetch/execute stages and the predictor.
//   master : fetch/EX side. Drives pc_F and the EX resolve fields, reads the lookup result.
//   slave  : predictor side. Reads pc_F and the resolve fields, drives the lookup result.
// Signals:
//   pc_F, prediction_F, target_F, state_F, hit_F : fetch-stage lookup.
//   update_en, pc_EX, taken_EX, target_EX         : execute-stage training.
//   lookup_hits, branches_resolved, mispredicts   : statistics (present only with BPU_STATS_EN).
// Optional feature macro: BPU_STATS_EN.
interface branch_predictor_if #(
  parameter int unsigned PC_W = 10
);
  logic [PC_W-1:0] pc_F;
  logic            prediction_F;
  logic [PC_W-1:0] target_F;
  logic [1:0]      state_F;
  logic            hit_F;
  logic            update_en;
  logic [PC_W-1:0] pc_EX;
  logic            taken_EX;
  logic [PC_W-1:0] target_EX;
`ifdef BPU_STATS_EN
  logic [15:0]     lookup_hits;
  logic [15:0]     branches_resolved;
  logic [15:0]     mispredicts;

  modport master (
    output pc_F, update_en, pc_EX, taken_EX, target_EX,
    input  prediction_F, target_F, state_F, hit_F,
    input  lookup_hits, branches_resolved, mispredicts
  );
  modport slave (
    input  pc_F, update_en, pc_EX, taken_EX, target_EX,
    output prediction_F, target_F, state_F, hit_F,
    output lookup_hits, branches_resolved, mispredicts
  );
`else
  modport master (
    output pc_F, update_en, pc_EX, taken_EX, target_EX,
    input  prediction_F, target_F, state_F, hit_F
  );
  modport slave (
    input  pc_F, update_en, pc_EX, taken_EX, target_EX,
    output prediction_F, target_F, state_F, hit_F
  );
`endif
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup at pc_F is purely combinational; training from the execute stage is applied on
// the rising clock edge and is only visible from the following cycle (no bypass).
// Ports:
//   clk : rising-edge clock.
//   rst : asynchronous active-low reset; clears the table and statistics.
//   bp  : branch_predictor_if slave port (lookup, resolve and optional statistics).
// Optional feature macro: BPU_STATS_EN adds saturating 16-bit lookup-hit, resolved-branch
// and mispredict counters.
module branch_predictor #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned IDX_W = 4
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int unsigned Depth = 1 << IDX_W;
  localparam int unsigned TagW  = PC_W - IDX_W;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CtrReset = 2'b01;
  localparam logic [1:0] CtrAlloc = 2'b10;

  logic            r_valid  [Depth];
  logic [TagW-1:0] r_tag    [Depth];
  logic [PC_W-1:0] r_target [Depth];
  logic [1:0]      r_ctr    [Depth];

  logic [IDX_W-1:0] w_idx_f;
  logic [TagW-1:0]  w_tag_f;
  logic             w_hit_f;
  logic [IDX_W-1:0] w_idx_ex;
  logic [TagW-1:0]  w_tag_ex;
  logic             w_hit_ex;
  logic [1:0]       w_ctr_ex;
  logic [1:0]       w_ctr_nxt;

  // Fetch-side lookup.
  always_comb begin
    w_idx_f = bp.pc_F[IDX_W-1:0];
    w_tag_f = bp.pc_F[PC_W-1:IDX_W];
    w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  end

  assign bp.hit_F        = w_hit_f;
  assign bp.prediction_F = w_hit_f & r_ctr[w_idx_f][1];
  assign bp.target_F     = w_hit_f ? r_target[w_idx_f] : '0;
  assign bp.state_F      = w_hit_f ? r_ctr[w_idx_f] : 2'b00;

  // Execute-side probe of the pre-update contents.
  always_comb begin
    w_idx_ex = bp.pc_EX[IDX_W-1:0];
    w_tag_ex = bp.pc_EX[PC_W-1:IDX_W];
    w_hit_ex = r_valid[w_idx_ex] && (r_tag[w_idx_ex] == w_tag_ex);
    w_ctr_ex = r_ctr[w_idx_ex];
  end

  // Saturating counter step.
  always_comb begin
    w_ctr_nxt = w_ctr_ex;
    if (bp.taken_EX) begin
      if (w_ctr_ex != 2'b11) w_ctr_nxt = w_ctr_ex + 2'd1;
    end else begin
      if (w_ctr_ex != 2'b00) w_ctr_nxt = w_ctr_ex - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CtrReset;
      end
    end else if (bp.update_en) begin
      if (w_hit_ex) begin
        r_ctr[w_idx_ex] <= w_ctr_nxt;
        if (bp.taken_EX) r_target[w_idx_ex] <= bp.target_EX;
      end else if (bp.taken_EX) begin
        // Taken miss allocates, evicting any alias at this index.
        r_valid[w_idx_ex]  <= 1'b1;
        r_tag[w_idx_ex]    <= w_tag_ex;
        r_target[w_idx_ex] <= bp.target_EX;
        r_ctr[w_idx_ex]    <= CtrAlloc;
      end
    end
  end

`ifdef BPU_STATS_EN
  logic [15:0] r_lookup_hits;
  logic [15:0] r_branches_resolved;
  logic [15:0] r_mispredicts;
  logic        w_pred_ex;

  // Prediction fetch would have seen for this branch, before this cycle's training.
  assign w_pred_ex = w_hit_ex & w_ctr_ex[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lookup_hits       <= '0;
      r_branches_resolved <= '0;
      r_mispredicts       <= '0;
    end else begin
      if (w_hit_f && (r_lookup_hits != 16'hFFFF)) r_lookup_hits <= r_lookup_hits + 16'd1;
      if (bp.update_en) begin
        if (r_branches_resolved != 16'hFFFF) begin
          r_branches_resolved <= r_branches_resolved + 16'd1;
        end
        if ((w_pred_ex != bp.taken_EX) && (r_mispredicts != 16'hFFFF)) begin
          r_mispredicts <= r_mispredicts + 16'd1;
        end
      end
    end
  end

  assign bp.lookup_hits       = r_lookup_hits;
  assign bp.branches_resolved = r_branches_resolved;
  assign bp.mispredicts       = r_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// checked against a table-level reference model. Statistics are checked with BPU_STATS_EN.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.PC_W(10)) bp_if ();

  branch_predictor #(.PC_W(10), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: one record per index, plain integers.
  bit m_valid  [16];
  int m_tag    [16];
  int m_target [16];
  int m_ctr    [16];
  int m_lh, m_br, m_mp;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_lh = 0; m_br = 0; m_mp = 0;
  endfunction

  function automatic void m_lookup(input int pc, output bit hit, output bit pred,
                                   output int tgt, output int st);
    int idx = pc % 16;
    hit  = m_valid[idx] && (m_tag[idx] == pc / 16);
    st   = hit ? m_ctr[idx] : 0;
    tgt  = hit ? m_target[idx] : 0;
    pred = hit && (st >= 2);
  endfunction

  function automatic void m_update(input int pc, input bit taken, input int tgt);
    int idx = pc % 16;
    if (m_valid[idx] && m_tag[idx] == pc / 16) begin
      if (taken) begin
        m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        m_target[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[idx] = 1; m_tag[idx] = pc / 16; m_target[idx] = tgt; m_ctr[idx] = 2;
    end
  endfunction

  // Advance one clock with the currently driven inputs and mirror the effect in the model.
  task automatic tick();
    bit h, p; int t, s;
    if (rst === 1'b1) begin
      m_lookup(int'(bp_if.pc_F), h, p, t, s);
      if (h && m_lh < 65535) m_lh++;
      if (bp_if.update_en) begin
        m_lookup(int'(bp_if.pc_EX), h, p, t, s);
        if (m_br < 65535) m_br++;
        if (p != bp_if.taken_EX && m_mp < 65535) m_mp++;
        m_update(int'(bp_if.pc_EX), bp_if.taken_EX, int'(bp_if.target_EX));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_update(input logic [9:0] pc, input logic taken, input logic [9:0] tgt);
    bp_if.update_en = 1'b1;
    bp_if.pc_EX     = pc;
    bp_if.taken_EX  = taken;
    bp_if.target_EX = tgt;
  endtask

  task automatic test_reset();
    bp_if.pc_F = 10'h014;
    #1;
    n_total++;
    if (bp_if.hit_F !== 1'b0) $display("FAIL reset_hit: got %b want 0", bp_if.hit_F);
    else n_pass++;
    n_total++;
    if (bp_if.prediction_F !== 1'b0) $display("FAIL reset_pred: got %b want 0", bp_if.prediction_F);
    else n_pass++;
    n_total++;
    if (bp_if.target_F !== 10'h000) $display("FAIL reset_target: got %h want 000", bp_if.target_F);
    else n_pass++;
    n_total++;
    if (bp_if.state_F !== 2'b00) $display("FAIL reset_state: got %b want 00", bp_if.state_F);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_train();
    bp_if.pc_F = 10'h014;
    drive_update(10'h014, 1'b1, 10'h030);
    #1;
    n_total++;
    if (bp_if.hit_F !== 1'b0) $display("FAIL train_pre_hit: got %b want 0", bp_if.hit_F);
    else n_pass++;
    tick();
    bp_if.update_en = 1'b0;
    #1;
    n_total++;
    if ({bp_if.hit_F, bp_if.prediction_F, bp_if.target_F, bp_if.state_F} !== {2'b11, 10'h030, 2'b10})
      $display("FAIL train_alloc: got hit=%b pred=%b tgt=%h st=%b want 1 1 030 10",
               bp_if.hit_F, bp_if.prediction_F, bp_if.target_F, bp_if.state_F);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_update(10'h014, 1'b1, 10'h030);
      tick();
    end
    bp_if.update_en = 1'b0;
    #1;
    n_total++;
    if (bp_if.state_F !== 2'b11) $display("FAIL train_sat_hi: got %b want 11", bp_if.state_F);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive_update(10'h014, 1'b0, 10'h3FF);
      tick();
    end
    bp_if.update_en = 1'b0;
    #1;
    n_total++;
    if ({bp_if.hit_F, bp_if.prediction_F, bp_if.target_F, bp_if.state_F} !== {2'b10, 10'h030, 2'b01})
      $display("FAIL train_down: got hit=%b pred=%b tgt=%h st=%b want 1 0 030 01",
               bp_if.hit_F, bp_if.prediction_F, bp_if.target_F, bp_if.state_F);
    else n_pass++;
  endtask

  task automatic test_alias();
    drive_update(10'h024, 1'b1, 10'h050);
    tick();
    bp_if.update_en = 1'b0;
    bp_if.pc_F = 10'h014;
    #1;
    n_total++;
    if ({bp_if.hit_F, bp_if.target_F} !== {1'b0, 10'h000})
      $display("FAIL alias_evict: got hit=%b tgt=%h want 0 000", bp_if.hit_F, bp_if.target_F);
    else n_pass++;
    bp_if.pc_F = 10'h024;
    #1;
    n_total++;
    if ({bp_if.hit_F, bp_if.target_F, bp_if.state_F} !== {1'b1, 10'h050, 2'b10})
      $display("FAIL alias_new: got hit=%b tgt=%h st=%b want 1 050 10",
               bp_if.hit_F, bp_if.target_F, bp_if.state_F);
    else n_pass++;
    drive_update(10'h034, 1'b0, 10'h111);
    tick();
    bp_if.update_en = 1'b0;
    #1;
    n_total++;
    if ({bp_if.hit_F, bp_if.target_F, bp_if.state_F} !== {1'b1, 10'h050, 2'b10})
      $display("FAIL alias_nt_miss: got hit=%b tgt=%h st=%b want 1 050 10",
               bp_if.hit_F, bp_if.target_F, bp_if.state_F);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    drive_update(10'h014, 1'b1, 10'h030);
    tick();
    bp_if.pc_F = 10'h014;
    drive_update(10'h014, 1'b1, 10'h031);
    #1;
    n_total++;
    if ({bp_if.target_F, bp_if.state_F} !== {10'h030, 2'b10})
      $display("FAIL same_cycle_old: got tgt=%h st=%b want 030 10", bp_if.target_F, bp_if.state_F);
    else n_pass++;
    tick();
    bp_if.update_en = 1'b0;
    #1;
    n_total++;
    if ({bp_if.target_F, bp_if.state_F} !== {10'h031, 2'b11})
      $display("FAIL same_cycle_new: got tgt=%h st=%b want 031 11", bp_if.target_F, bp_if.state_F);
    else n_pass++;
  endtask

  task automatic test_random();
    bit h, p; int t, s;
    logic [13:0] exp_v, got_v;
    for (int i = 0; i < 300; i++) begin
      bp_if.pc_F = 10'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      bp_if.update_en = 1'($urandom_range(0, 1));
      bp_if.pc_EX = 10'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      bp_if.taken_EX = 1'($urandom_range(0, 1));
      bp_if.target_EX = 10'($urandom_range(0, 1023));
      #1;
      m_lookup(int'(bp_if.pc_F), h, p, t, s);
      exp_v = {h, p, 10'(t), 2'(s)};
      got_v = {bp_if.hit_F, bp_if.prediction_F, bp_if.target_F, bp_if.state_F};
      n_total++;
      if (got_v !== exp_v)
        $display("FAIL random_lookup[%0d] pc=%h: got %h want %h", i, bp_if.pc_F, got_v, exp_v);
      else n_pass++;
      tick();
    end
    bp_if.update_en = 1'b0;
`ifdef BPU_STATS_EN
    n_total++;
    if ({bp_if.lookup_hits, bp_if.branches_resolved, bp_if.mispredicts} !==
        {16'(m_lh), 16'(m_br), 16'(m_mp)})
      $display("FAIL random_stats: got %0d/%0d/%0d want %0d/%0d/%0d", bp_if.lookup_hits,
               bp_if.branches_resolved, bp_if.mispredicts, m_lh, m_br, m_mp);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    drive_update(10'h014, 1'b1, 10'h0AA);
    tick();
    bp_if.pc_F = 10'h014;
    drive_update(10'h014, 1'b0, 10'h000);
    #1;
    n_total++;
    if (bp_if.hit_F !== 1'b1) $display("FAIL areset_pre_hit: got %b want 1", bp_if.hit_F);
    else n_pass++;
    #1;
    rst = 1'b0;
    m_reset();
    #1;
    n_total++;
    if ({bp_if.hit_F, bp_if.prediction_F, bp_if.target_F, bp_if.state_F} !== 14'h0)
      $display("FAIL areset_async: got hit=%b pred=%b tgt=%h st=%b want all 0",
               bp_if.hit_F, bp_if.prediction_F, bp_if.target_F, bp_if.state_F);
    else n_pass++;
    tick();
    @(negedge clk);
    rst = 1'b1;
    bp_if.update_en = 1'b0;
    tick();
    n_total++;
    if (bp_if.hit_F !== 1'b0) $display("FAIL areset_update_lost: got %b want 0", bp_if.hit_F);
    else n_pass++;
`ifdef BPU_STATS_EN
    n_total++;
    if ({bp_if.lookup_hits, bp_if.branches_resolved, bp_if.mispredicts} !== 48'h0)
      $display("FAIL areset_stats: got %0d/%0d/%0d want 0/0/0", bp_if.lookup_hits,
               bp_if.branches_resolved, bp_if.mispredicts);
    else n_pass++;
`endif
  endtask

`ifdef BPU_STATS_EN
  task automatic test_stats();
    bp_if.pc_F = 10'h200;
    for (int i = 0; i < 3; i++) begin
      drive_update(10'h014, 1'b1, 10'h030);
      tick();
    end
    drive_update(10'h014, 1'b0, 10'h000);
    tick();
    bp_if.update_en = 1'b0;
    // Taken-miss allocation plus the NT resolve of a strong-taken entry.
    n_total++;
    if (bp_if.mispredicts !== 16'd2)
      $display("FAIL stats_mispredict: got %0d want 2", bp_if.mispredicts);
    else n_pass++;
    n_total++;
    if ({bp_if.lookup_hits, bp_if.branches_resolved, bp_if.mispredicts} !==
        {16'(m_lh), 16'(m_br), 16'(m_mp)})
      $display("FAIL stats_model: got %0d/%0d/%0d want %0d/%0d/%0d", bp_if.lookup_hits,
               bp_if.branches_resolved, bp_if.mispredicts, m_lh, m_br, m_mp);
    else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b0;
    bp_if.pc_F = '0;
    bp_if.update_en = 1'b0;
    bp_if.pc_EX = '0;
    bp_if.taken_EX = 1'b0;
    bp_if.target_EX = '0;
    m_reset();
    #2;
    test_reset();
    test_train();
    test_alias();
    test_same_cycle();
    test_random();
    test_async_reset();
`ifdef BPU_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
